// File: rtl/cache_2way_param_if.sv
// Bundle between the MEM stage, the data cache and the backing-memory controller.
// The cache is the slave; the pipeline/memory environment is the master.
interface cache_2way_param_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       rdata;
  logic              freeze;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output addr, wdata, rd_en, wr_en, mem_rdata, mem_ack,
    input  rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  addr, wdata, rd_en, wr_en, mem_rdata, mem_ack,
    output rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_2way_param.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Optional CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_2way_param #(
  parameter int ADDR_W  = 18,
  parameter int INDEX_W = 6
) (
  input  logic clk,
  input  logic rst,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  cache_2way_param_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - 3;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]  valid0, valid1, lru;  // lru = 1: way0 is the next victim
  logic [TAG_W-1:0] tag0  [SETS];
  logic [TAG_W-1:0] tag1  [SETS];
  logic [63:0]      data0 [SETS];
  logic [63:0]      data1 [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hit, victim;
  logic [63:0]        hit_line;
  logic               read_hit, read_miss, write_hit, fill;

  assign idx      = bus.addr[INDEX_W+2:3];
  assign tag      = bus.addr[ADDR_W-1:INDEX_W+3];
  assign hit0     = valid0[idx] && (tag0[idx] == tag);
  assign hit1     = valid1[idx] && (tag1[idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit0 ? data0[idx] : data1[idx];
  // Invalid ways are filled first; only a full set consults lru.
  assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : !lru[idx]);

  assign read_hit  = (state == IDLE) && bus.rd_en && hit;
  assign read_miss = (state == IDLE) && bus.rd_en && !hit;
  assign write_hit = (state == IDLE) && !bus.rd_en && bus.wr_en && hit;
  assign fill      = (state == RD_MISS) && bus.mem_ack;

  assign bus.rdata     = (bus.rd_en && hit) ? (bus.addr[2] ? hit_line[63:32] : hit_line[31:0]) : '0;
  assign bus.mem_req   = (state != IDLE);
  assign bus.mem_we    = (state == WR_THRU);
  assign bus.mem_addr  = bus.addr & ~ADDR_W'((state == WR_THRU) ? 3 : 7);
  assign bus.mem_wdata = bus.wdata;

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    bus.freeze = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rd_en) begin
          if (!hit) begin
            bus.freeze = 1'b1;
            state_nxt  = RD_MISS;
          end
        end else if (bus.wr_en) begin
          bus.freeze = 1'b1;
          state_nxt  = WR_THRU;
        end
      end
      RD_MISS: begin
        bus.freeze = 1'b1;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      WR_THRU: begin
        bus.freeze = !bus.mem_ack;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= state_nxt;
      if (read_hit) lru[idx] <= !hit0;
      if (fill) begin
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
        lru[idx] <= victim;
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= bus.mem_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= bus.mem_rdata;
      end
    end
    if (write_hit) begin
      if (hit0) begin
        if (bus.addr[2]) data0[idx][63:32] <= bus.wdata;
        else             data0[idx][31:0]  <= bus.wdata;
      end else begin
        if (bus.addr[2]) data1[idx][63:32] <= bus.wdata;
        else             data1[idx][31:0]  <= bus.wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic after_fill;

  // The re-lookup right after a fill is the tail of a miss, not a new hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= fill;
      if (read_hit && !after_fill && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
      if (read_miss && (miss_cnt != '1))              miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_2way_param.sv
// Self-checking bench: directed scenarios plus random loads/stores against a
// backing-memory array and a per-set recency-list model of cache residency.
module tb_cache_2way_param;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cache_2way_param_if #(.ADDR_W(18)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  cache_2way_param #(.ADDR_W(18), .INDEX_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CACHE_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Backing memory (word addressed) and residency model: per set, the most and
  // least recently used line numbers; cache data always mirrors memory.
  logic [31:0] bmem [65536];
  int mru_l [64];
  int lru_l [64];
  int cnt   [64];
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic bit model_present(input int line);
    int s = line % 64;
    return (cnt[s] > 0 && mru_l[s] == line) || (cnt[s] > 1 && lru_l[s] == line);
  endfunction

  function automatic void model_touch(input int line);
    int s = line % 64;
    if (cnt[s] > 0 && mru_l[s] == line) return;
    if (cnt[s] > 1 && lru_l[s] == line) begin
      lru_l[s] = mru_l[s];
      mru_l[s] = line;
      return;
    end
    lru_l[s] = mru_l[s];
    mru_l[s] = line;
    if (cnt[s] < 2) cnt[s]++;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) cnt[s] = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic do_read(input logic [17:0] a, input int lat, output bit was_hit);
    int line = int'(a >> 3);
    logic [31:0] w = bmem[a >> 2];
    bit pred = model_present(line);
    int fz = 1;
    bus.addr  = a;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    was_hit = !bus.freeze;
    check("rd_hit_status", 64'(was_hit), 64'(pred));
    check("rd_req_idle", 64'(bus.mem_req), 64'd0);
    if (!bus.freeze) begin
      check("rd_hit_data", 64'(bus.rdata), 64'(w));
      exp_hits++;
    end else begin
      exp_misses++;
      for (int c = 1; c <= lat; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          check("rd_mem_req", 64'(bus.mem_req), 64'd1);
          check("rd_mem_we", 64'(bus.mem_we), 64'd0);
          check("rd_mem_addr", 64'(bus.mem_addr), 64'(a & 18'h3FFF8));
        end
        if (c == lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = {bmem[(line << 1) + 1], bmem[line << 1]};
          #1;
        end
        if (bus.freeze) fz++;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      check("rd_freeze_cycles", 64'(fz), 64'(lat + 1));
      check("rd_refill_freeze", 64'(bus.freeze), 64'd0);
      check("rd_refill_req", 64'(bus.mem_req), 64'd0);
      check("rd_refill_data", 64'(bus.rdata), 64'(w));
    end
    model_touch(line);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d, input int lat);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    check("wr_freeze_idle", 64'(bus.freeze), 64'd1);
    check("wr_req_idle", 64'(bus.mem_req), 64'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check("wr_mem_req", 64'(bus.mem_req), 64'd1);
        check("wr_mem_we", 64'(bus.mem_we), 64'd1);
        check("wr_mem_addr", 64'(bus.mem_addr), 64'(a & 18'h3FFFC));
        check("wr_mem_wdata", 64'(bus.mem_wdata), 64'(d));
      end
      if (c == lat) begin
        bus.mem_ack = 1'b1;
        #1;
        check("wr_ack_freeze", 64'(bus.freeze), 64'd0);
      end else begin
        check("wr_wait_freeze", 64'(bus.freeze), 64'd1);
      end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    bus.wr_en   = 1'b0;
    bmem[a >> 2] = d;
    #1;
    check("wr_done_req", 64'(bus.mem_req), 64'd0);
  endtask

`ifdef CACHE_STATS_EN
  task automatic check_stats(input string name);
    check({name, "_hits"}, 64'(hit_cnt), 64'(exp_hits));
    check({name, "_misses"}, 64'(miss_cnt), 64'(exp_misses));
  endtask
`endif

  initial begin
    bit h;
    logic [17:0] ra;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    for (int i = 0; i < 65536; i++) bmem[i] = $urandom;
    bmem[18'h00010 >> 2] = 32'hAAAAAAAA;
    bmem[18'h00014 >> 2] = 32'hBBBBBBBB;
    model_reset();

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_freeze", 64'(bus.freeze), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);

    // Cold read with ack latency 3, then the neighbouring word hits
    do_read(18'h00010, 3, h);
    check("cold_miss", 64'(h), 64'd0);
    do_read(18'h00014, 1, h);
    check("neighbour_hit", 64'(h), 64'd1);
`ifdef CACHE_STATS_EN
    check("stats_s1_hits", 64'(hit_cnt), 64'd1);
    check("stats_s1_misses", 64'(miss_cnt), 64'd1);
`endif

    // LRU eviction within one set
    do_read(18'h00000, 2, h);
    do_read(18'h00200, 2, h);
    do_read(18'h00000, 1, h);
    check("lru_reread_hit", 64'(h), 64'd1);
    do_read(18'h00400, 2, h);
    do_read(18'h00000, 1, h);
    check("lru_keep_hit", 64'(h), 64'd1);
    do_read(18'h00200, 2, h);
    check("lru_evicted_miss", 64'(h), 64'd0);

    // Store hit updates the cached word, the other word untouched
    do_read(18'h00000, 1, h);
    do_write(18'h00004, 32'hDEADBEEF, 2);
    do_read(18'h00004, 1, h);
    check("wr_hit_reread", 64'(h), 64'd1);
    check("wr_hit_value", 64'(bmem[1]), 64'hDEADBEEF);
    do_read(18'h00000, 1, h);
    check("wr_other_word_hit", 64'(h), 64'd1);

    // Store miss is write-through only
    do_write(18'h00800, 32'h12345678, 3);
    do_read(18'h00800, 2, h);
    check("no_alloc_miss", 64'(h), 64'd0);

    // Reset two cycles into a read miss
    bus.addr  = 18'h01000;
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    @(posedge clk); #1;
    check("midrst_req", 64'(bus.mem_req), 64'd0);
    check("midrst_freeze", 64'(bus.freeze), 64'd0);
    rst = 1'b0;
    model_reset();
    do_read(18'h01000, 2, h);
    check("midrst_reread_miss", 64'(h), 64'd0);

    // Stray ack while idle is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {$urandom, $urandom};
    #1;
    check("idle_ack_freeze", 64'(bus.freeze), 64'd0);
    check("idle_ack_req", 64'(bus.mem_req), 64'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    do_read(18'h01000, 1, h);
    check("idle_ack_still_hit", 64'(h), 64'd1);

    // Random loads/stores over a small pool of tags and sets
    for (int n = 0; n < 200; n++) begin
      ra = 18'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3)
              | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) begin
        do_read(ra, $urandom_range(1, 4), h);
      end else begin
        do_write(ra, $urandom, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("idle_rdata_zero", 64'(bus.rdata), 64'd0);
      end
    end
`ifdef CACHE_STATS_EN
    check_stats("stats_final");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
